// File: rtl/adbg_jsp_pkg.sv
// Shared definitions for the JTAG serial port APB poller: FSM states,
// line-status bit positions and default register addresses.
package adbg_jsp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LSR_SETUP,
        LSR_ACCESS,
        RBR_SETUP,
        RBR_ACCESS,
        THR_SETUP,
        THR_ACCESS
    } jsp_state_e;

    localparam int LSR_DR_BIT   = 0;
    localparam int LSR_THRE_BIT = 5;

    localparam logic [2:0] LSR_ADDR_DEFAULT  = 3'd5;
    localparam logic [2:0] DATA_ADDR_DEFAULT = 3'd0;

endpackage

// File: rtl/adbg_jsp_apb_poller.sv
// APB master that polls the JSP line-status register and moves single bytes
// between the JSP RBR/THR and one-entry rx/tx holding registers.
module adbg_jsp_apb_poller
    import adbg_jsp_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 16,
    parameter logic [2:0]  LSR_ADDR    = LSR_ADDR_DEFAULT,
    parameter logic [2:0]  DATA_ADDR   = DATA_ADDR_DEFAULT
) (
    input  logic       PCLK,
    input  logic       rst_i,
    output logic       PSEL,
    output logic       PENABLE,
    output logic [2:0] PADDR,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       int_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       err_o
);

    localparam logic [15:0] RELOAD = 16'(POLL_CYCLES - 1);

    jsp_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [2:0]  paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_full_q, tx_full_d;
    logic        err_q, err_d;

    logic        start_setup;
    jsp_state_e  setup_state;
    logic        to_idle;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_data_d   = tx_data_q;
        tx_full_d   = tx_full_q;
        err_d       = 1'b0;
        start_setup = 1'b0;
        setup_state = LSR_SETUP;
        to_idle     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                if (int_i || cnt_q == 16'd0 || tx_full_q) start_setup = 1'b1;
            end
            LSR_SETUP: begin state_d = LSR_ACCESS; penable_d = 1'b1; end
            RBR_SETUP: begin state_d = RBR_ACCESS; penable_d = 1'b1; end
            THR_SETUP: begin state_d = THR_ACCESS; penable_d = 1'b1; end
            LSR_ACCESS: if (PREADY) begin
                if (PSLVERR) begin
                    err_d   = 1'b1;
                    to_idle = 1'b1;
                end else if (PRDATA[LSR_DR_BIT] && !rx_valid_q) begin
                    start_setup = 1'b1;
                    setup_state = RBR_SETUP;
                end else if (PRDATA[LSR_THRE_BIT] && tx_full_q) begin
                    start_setup = 1'b1;
                    setup_state = THR_SETUP;
                end else begin
                    to_idle = 1'b1;
                end
            end
            RBR_ACCESS: if (PREADY) begin
                if (PSLVERR) begin
                    err_d   = 1'b1;
                    to_idle = 1'b1;
                end else begin
                    rx_data_d  = PRDATA;
                    rx_valid_d = 1'b1;
                    // A pending tx byte gets a fresh LSR check straight away.
                    if (tx_full_q) start_setup = 1'b1;
                    else           to_idle     = 1'b1;
                end
            end
            THR_ACCESS: if (PREADY) begin
                if (PSLVERR) begin
                    err_d = 1'b1;
                end else begin
                    tx_full_d = 1'b0;
                end
                to_idle = 1'b1;
            end
            default: to_idle = 1'b1;
        endcase

        if (start_setup) begin
            state_d   = setup_state;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = (setup_state == LSR_SETUP) ? LSR_ADDR : DATA_ADDR;
            pwrite_d  = (setup_state == THR_SETUP);
            pwdata_d  = (setup_state == THR_SETUP) ? tx_data_q : 8'd0;
        end
        if (to_idle) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            cnt_d     = RELOAD;
        end

        // Capture only happens while rx is empty, so this never races it.
        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
        if (!tx_full_q && tx_valid_i) begin
            tx_full_d = 1'b1;
            tx_data_d = tx_data_i;
        end
    end

    always_ff @(posedge PCLK or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= RELOAD;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= 3'd0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_full_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_full_q  <= tx_full_d;
            err_q      <= err_d;
        end
    end

    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = !tx_full_q;
    assign err_o      = err_q;

endmodule

// File: doc/adbg_jsp_apb_poller.md
ADBG_JSP_APB_POLLER -- requirements
Module: adbg_jsp_apb_poller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named PCLK and rst_i.
REQ-002 The block SHALL provide parameter POLL_CYCLES, default 16, giving the idle cycles between LSR polls when int_i is low; legal range 2..65535.
REQ-003 The block SHALL provide parameter LSR_ADDR, default 3'd5, giving the line-status register address.
REQ-004 The block SHALL provide parameter DATA_ADDR, default 3'd0, giving the RBR/THR address.
REQ-005 The block SHALL provide these ports, one per line (name, direction, width, meaning):
- PCLK  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- PSEL  out  1  APB select to the JSP APB slave
- PENABLE  out  1  APB access phase
- PADDR  out  3  register address
- PWRITE  out  1  write access
- PWDATA  out  8  write data
- PRDATA  in  8  read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- int_i  in  1  JSP interrupt; requests an immediate poll
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  rx_data_o valid
- rx_ready_i  in  1  consumer accepts the byte
- tx_data_i  in  8  byte to send
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  tx holding register empty
- err_o  out  1  one-cycle pulse on a PSLVERR-terminated access

Function
REQ-006 The block SHALL implement the states IDLE, LSR_SETUP, LSR_ACCESS, RBR_SETUP, RBR_ACCESS, THR_SETUP and THR_ACCESS.
REQ-007 In IDLE, the poll counter SHALL decrement every cycle while it is nonzero.
REQ-008 In IDLE, the block SHALL go to LSR_SETUP when int_i=1, when the counter is 0, or when the tx holding register is full.
REQ-009 Each SETUP state SHALL drive PSEL=1, PENABLE=0 and a stable PADDR/PWRITE/PWDATA for exactly one cycle, then move to its ACCESS state.
REQ-010 Each ACCESS state SHALL hold PSEL=1 and PENABLE=1 with unchanged address and data until PREADY=1; wait states are unbounded.
REQ-011 On completion of LSR_ACCESS (PREADY=1, PSLVERR=0), the next state SHALL be chosen as follows:
- PRDATA[0] (DR)=1 and rx holding empty -> RBR_SETUP;
- otherwise, PRDATA[5] (THRE)=1 and tx holding full -> THR_SETUP;
- otherwise -> IDLE, with the counter reloaded to POLL_CYCLES-1.
REQ-012 On completion of RBR_ACCESS, PRDATA SHALL be captured into the rx holding register and rx_valid_o set on the next cycle.
REQ-013 After RBR_ACCESS, the next state SHALL be LSR_SETUP if the tx holding register is full, else IDLE with the counter reloaded.
REQ-014 On completion of THR_ACCESS, the tx holding register SHALL be emptied, and the next state SHALL be IDLE with the counter reloaded.
REQ-015 The rx output SHALL use a single-entry holding register: rx_valid_o clears on the cycle after rx_valid_o=1 and rx_ready_i=1.
REQ-016 rx_data_o SHALL remain stable while rx_valid_o=1 and rx_ready_i=0.
REQ-017 The tx input SHALL use a single-entry holding register: tx_ready_o=1 exactly when it is empty, and a byte is accepted on tx_valid_i=1 and tx_ready_o=1.
REQ-018 Simultaneous events: a tx accept in the same cycle as THR completion SHALL NOT occur, because tx_ready_o=0 while the holding register is full; an rx consume during RBR_ACCESS SHALL be impossible, because RBR is read only when rx holding is empty.
REQ-019 On any ACCESS completing with PREADY=1 and PSLVERR=1, the block SHALL capture no data, leave tx holding unchanged, pulse err_o for one cycle, and return to IDLE with the counter reloaded.
REQ-020 PSEL and PENABLE SHALL be 0 in IDLE; there SHALL be no back-to-back access without a SETUP cycle.
REQ-021 The block SHALL have at most one outstanding APB transfer.

Reset
REQ-022 On rst_i=1, the block SHALL asynchronously force: state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rx_valid_o=0, rx_data_o=0, tx_ready_o=1 (tx holding empty), err_o=0, counter=POLL_CYCLES-1.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer immediately and discard any held bytes.

Structure
REQ-024 The state enumeration, LSR bit indices (DR=0, THRE=5) and default register addresses SHALL reside in adbg_jsp_pkg.
REQ-025 The block SHALL be a single module with no sub-modules.

Verification
REQ-026 Scenario: reset with POLL_CYCLES=16, idle slave (LSR=8'h20), tx_valid_i=0 -> the first LSR read starts 16 cycles after reset release, with no RBR/THR access.
REQ-027 Scenario: int_i pulse with LSR=8'h01 and RBR=8'hA5 -> LSR_SETUP on the next cycle, then an RBR read, then rx_valid_o=1 with rx_data_o=8'hA5, held until rx_ready_i=1.
REQ-028 Scenario: tx byte 8'h3C with LSR=8'h20 and PREADY delayed 3 cycles -> a THR write with PWDATA=8'h3C held stable across the wait states, after which tx_ready_o returns to 1.
REQ-029 Scenario: LSR=8'h21, rx holding full, tx pending -> a THR write only, with no RBR read; after rx_ready_i, the next poll reads RBR.
REQ-030 Scenario: PSLVERR=1 on an RBR access -> err_o pulses once, rx_valid_o stays 0, and the block returns to IDLE.
REQ-031 Scenario: rst_i asserted during THR_ACCESS -> PSEL=PENABLE=0 in the same cycle, tx_ready_o=1, and no write completes.
